// File: rtl/mm6_mac_sequencer_pkg.sv
// Shared encodings for the MAC sequencer: multiplier mode codes, FSM states
// and the fixed operand/product widths of the shared multiplier.
package mm6_mac_sequencer_pkg;

  typedef enum logic [1:0] {
    CT_ILLEGAL = 2'b00,
    M3x3       = 2'b01,
    M6x3       = 2'b10,
    M6x6       = 2'b11
  } convtype_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int OPND_W  = 6;
  localparam int MUL_P_W = 14;

endpackage

// File: rtl/mm6_mac_sequencer_if.sv
// Bundle of descriptor, operand, multiplier and result signals of the MAC sequencer.
// slave is the sequencer's view; master is the environment (source, sink, multiplier).
interface mm6_mac_sequencer_if
  import mm6_mac_sequencer_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
);

  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [1:0]               cfg_convtype;
  logic [LEN_W-1:0]         cfg_len;

  logic                     in_valid;
  logic                     in_ready;
  logic [OPND_W-1:0]        in_d;
  logic [OPND_W-1:0]        in_w1;
  logic [OPND_W-1:0]        in_w2;

  logic [OPND_W-1:0]        mul_d;
  logic [OPND_W-1:0]        mul_w1;
  logic [OPND_W-1:0]        mul_w2;
  logic [1:0]               mul_convtype;
  logic [MUL_P_W-1:0]       mul_p;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_acc;
  logic                     out_ovf;
  logic                     out_err;
  logic                     busy;

  modport slave (
    input  cfg_valid, cfg_convtype, cfg_len,
    input  in_valid, in_d, in_w1, in_w2,
    input  mul_p, out_ready,
    output cfg_ready, in_ready,
    output mul_d, mul_w1, mul_w2, mul_convtype,
    output out_valid, out_acc, out_ovf, out_err, busy
  );

  modport master (
    output cfg_valid, cfg_convtype, cfg_len,
    output in_valid, in_d, in_w1, in_w2,
    output mul_p, out_ready,
    input  cfg_ready, in_ready,
    input  mul_d, mul_w1, mul_w2, mul_convtype,
    input  out_valid, out_acc, out_ovf, out_err, busy
  );

endinterface

// File: rtl/mm6_sat_acc.sv
// Signed saturating accumulator with a sticky overflow flag; clear wins over enable.
module mm6_sat_acc #(
  parameter int ACC_W = 24,
  parameter int ADD_W = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    enable,
  input  logic signed [ADD_W-1:0] addend,
  output logic signed [ACC_W-1:0] acc,
  output logic                    ovf
);

  logic [ACC_W:0] sum;
  logic           pos_sat;
  logic           neg_sat;

  // One guard bit: the top two sum bits disagree exactly when the true sum left the ACC_W range.
  assign sum     = {acc[ACC_W-1], acc} + {{(ACC_W+1-ADD_W){addend[ADD_W-1]}}, addend};
  assign pos_sat = (sum[ACC_W -: 2] == 2'b01);
  assign neg_sat = (sum[ACC_W -: 2] == 2'b10);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (enable) begin
      if (pos_sat)      acc <= {1'b0, {(ACC_W-1){1'b1}}};
      else if (neg_sat) acc <= {1'b1, {(ACC_W-1){1'b0}}};
      else              acc <= sum[ACC_W-1:0];
      ovf <= ovf | pos_sat | neg_sat;
    end
  end

endmodule

// File: rtl/mm6_mac_sequencer.sv
// Job sequencer for a shared 6-bit multiplier: issues operand beats, accumulates
// products two edges later with saturation, and hands back one result per job.
module mm6_mac_sequencer
  import mm6_mac_sequencer_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  mm6_mac_sequencer_if.slave  bus
);

  state_e             state;
  state_e             state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issue_cnt;
  logic [LEN_W-1:0]   retire_cnt;
  logic               v1;
  logic               v2;
  logic               err_q;
  logic [OPND_W-1:0]  mul_d_q;
  logic [OPND_W-1:0]  mul_w1_q;
  logic [OPND_W-1:0]  mul_w2_q;
  logic [1:0]         mul_ct_q;

  logic               accept;
  logic               issue;
  logic               last_issue;
  logic               last_retire;

  assign accept      = bus.cfg_valid && (state == IDLE);
  assign issue       = bus.in_valid && (state == RUN);
  assign last_issue  = issue && (issue_cnt == len_q - LEN_W'(1));
  assign last_retire = v2 && (retire_cnt == len_q - LEN_W'(1));

  // NOTE: next state is given a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) begin
               if (bus.cfg_convtype == CT_ILLEGAL || bus.cfg_len == '0) state_nxt = DONE;
               else                                                      state_nxt = RUN;
             end
      RUN:   if (last_issue)    state_nxt = DRAIN;
      DRAIN: if (last_retire)   state_nxt = DONE;
      DONE:  if (bus.out_ready) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      issue_cnt  <= '0;
      retire_cnt <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      err_q      <= 1'b0;
      mul_d_q    <= '0;
      mul_w1_q   <= '0;
      mul_w2_q   <= '0;
      mul_ct_q   <= '0;
    end else begin
      state <= state_nxt;
      v1    <= issue;
      v2    <= v1;
      if (accept) begin
        len_q      <= bus.cfg_len;
        mul_ct_q   <= bus.cfg_convtype;
        err_q      <= (bus.cfg_convtype == CT_ILLEGAL);
        issue_cnt  <= '0;
        retire_cnt <= '0;
      end else begin
        if (issue) issue_cnt  <= issue_cnt + LEN_W'(1);
        if (v2)    retire_cnt <= retire_cnt + LEN_W'(1);
      end
      if (issue) begin
        mul_d_q  <= bus.in_d;
        mul_w1_q <= bus.in_w1;
        mul_w2_q <= bus.in_w2;
      end
    end
  end

  // v2 marks the edge on which the multiplier's registered product belongs to an issued beat.
  mm6_sat_acc #(
    .ACC_W (ACC_W),
    .ADD_W (MUL_P_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (v2),
    .addend ($signed(bus.mul_p)),
    .acc    (bus.out_acc),
    .ovf    (bus.out_ovf)
  );

  assign bus.cfg_ready    = (state == IDLE);
  assign bus.in_ready     = (state == RUN);
  assign bus.out_valid    = (state == DONE);
  assign bus.busy         = (state != IDLE);
  assign bus.out_err      = err_q;
  assign bus.mul_d        = mul_d_q;
  assign bus.mul_w1       = mul_w1_q;
  assign bus.mul_w2       = mul_w2_q;
  assign bus.mul_convtype = mul_ct_q;

endmodule

// File: tb/tb_mm6_mac_sequencer.sv
// Self-checking bench for mm6_mac_sequencer: models the shared multiplier and
// scoreboards expected job results against a saturating reference sum.
module tb_mm6_mac_sequencer;

  localparam int ACC_W = 24;
  localparam int LEN_W = 8;

  typedef struct {
    longint acc;
    logic   ovf;
    logic   err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t sb16[$];
  logic [5:0] bd[256];
  logic [5:0] bw1[256];
  logic [5:0] bw2[256];
  logic [13:0] mul_p_q;
  logic [13:0] mul16_p_q;

  always #5 clk = ~clk;

  mm6_mac_sequencer_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();
  mm6_mac_sequencer_if #(.ACC_W(16),    .LEN_W(LEN_W)) bus16 ();

  mm6_mac_sequencer #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  mm6_mac_sequencer #(.ACC_W(16),    .LEN_W(LEN_W)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  function automatic logic [13:0] mul_model(logic [1:0] ct, logic [5:0] d, logic [5:0] w1, logic [5:0] w2);
    int p;
    case (ct)
      2'b11:   p = int'(d) * int'($signed(w1));
      2'b10:   p = int'(d) * int'($signed(w1[2:0])) + int'(d) * int'($signed(w2[2:0]));
      2'b01:   p = int'(d[2:0]) * int'($signed(w1[2:0])) + int'(d[5:3]) * int'($signed(w2[2:0]));
      default: p = 0;
    endcase
    return 14'(p);
  endfunction

  // Shared multiplier: product registered one edge after its operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_p_q   <= '0;
      mul16_p_q <= '0;
    end else begin
      mul_p_q   <= mul_model(bus.mul_convtype, bus.mul_d, bus.mul_w1, bus.mul_w2);
      mul16_p_q <= mul_model(bus16.mul_convtype, bus16.mul_d, bus16.mul_w1, bus16.mul_w2);
    end
  end
  assign bus.mul_p   = mul_p_q;
  assign bus16.mul_p = mul16_p_q;

  function automatic exp_t model(logic [1:0] ct, int len, int w);
    exp_t   r;
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
    longint s;
    r.acc = 0;
    r.ovf = 1'b0;
    r.err = (ct == 2'b00);
    if (ct != 2'b00) begin
      for (int i = 0; i < len; i++) begin
        s = r.acc + longint'($signed(mul_model(ct, bd[i], bw1[i], bw2[i])));
        if (s > hi)      begin s = hi; r.ovf = 1'b1; end
        else if (s < lo) begin s = lo; r.ovf = 1'b1; end
        r.acc = s;
      end
    end
    return r;
  endfunction

  task automatic send_cfg(logic [1:0] ct, int len);
    @(negedge clk);
    if (bus.cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_ready_idle: got %b want 1", bus.cfg_ready);
    end
    vectors++;
    bus.cfg_valid    = 1'b1;
    bus.cfg_convtype = ct;
    bus.cfg_len      = 8'(len);
    sb.push_back(model(ct, len, ACC_W));
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic send_beats(int len, int gap_pct, logic hog_cfg);
    int i = 0;
    int budget = 0;
    if (hog_cfg) begin
      bus.cfg_valid    = 1'b1;
      bus.cfg_convtype = 2'b00;
      bus.cfg_len      = 8'd0;
    end
    while (i < len && budget < 5000) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        bus.in_valid = 1'b0;
      end else begin
        if (bus.in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL in_ready_run: beat %0d got %b want 1", i, bus.in_ready);
        end
        vectors++;
        bus.in_valid = 1'b1;
        bus.in_d     = bd[i];
        bus.in_w1    = bw1[i];
        bus.in_w2    = bw2[i];
        i++;
      end
      @(negedge clk);
      budget++;
    end
    bus.in_valid = 1'b0;
    if (hog_cfg) begin
      if (bus.cfg_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL cfg_ready_busy: got %b want 0", bus.cfg_ready);
      end
      vectors++;
      bus.cfg_valid = 1'b0;
    end
  endtask

  task automatic collect(logic [1:0] ct, int hold);
    int   n = 0;
    exp_t e;
    while (bus.out_valid !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
      miscompares++;
      $display("FAIL result_timeout: out_valid %b queue %0d", bus.out_valid, sb.size());
      sb.delete();
      return;
    end
    e = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      if (bus.out_acc !== 24'(e.acc)) begin
        miscompares++;
        $display("FAIL out_acc: cyc %0d got %0d want %0d", h, $signed(bus.out_acc), e.acc);
      end
      if (bus.out_ovf !== e.ovf || bus.out_err !== e.err) begin
        miscompares++;
        $display("FAIL flags: got ovf %b err %b want ovf %b err %b", bus.out_ovf, bus.out_err, e.ovf, e.err);
      end
      if (bus.mul_convtype !== ct || bus.out_valid !== 1'b1 || bus.cfg_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL done_state: convtype %b valid %b cfg_ready %b want %b 1 0",
                 bus.mul_convtype, bus.out_valid, bus.cfg_ready, ct);
      end
      vectors += 3;
      if (h < hold) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    if (bus.out_valid !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release: out_valid %b cfg_ready %b want 0 1", bus.out_valid, bus.cfg_ready);
    end
    vectors++;
  endtask

  task automatic run_job(logic [1:0] ct, int len, int gap_pct, logic hog_cfg);
    send_cfg(ct, len);
    if (ct != 2'b00 && len > 0) send_beats(len, gap_pct, hog_cfg);
    collect(ct, 0);
  endtask

  task automatic test_reset;
    if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy %b cfg_ready %b in_ready %b out_valid %b want 0 1 0 0",
               bus.busy, bus.cfg_ready, bus.in_ready, bus.out_valid);
    end
    if (bus.out_acc !== '0 || bus.out_ovf !== 1'b0 || bus.out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_result: acc %0d ovf %b err %b want 0 0 0", bus.out_acc, bus.out_ovf, bus.out_err);
    end
    if ({bus.mul_d, bus.mul_w1, bus.mul_w2, bus.mul_convtype} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_mul: got %h want 0", {bus.mul_d, bus.mul_w1, bus.mul_w2, bus.mul_convtype});
    end
    vectors += 3;
  endtask

  task automatic test_basic;
    bd[0] = 6'd63; bw1[0] = 6'h20; bw2[0] = 6'd7;
    bd[1] = 6'd10; bw1[1] = 6'd5;  bw2[1] = 6'd2;
    bd[2] = 6'd1;  bw1[2] = 6'h3f; bw2[2] = 6'd9;
    run_job(2'b11, 3, 0, 1'b1);
  endtask

  task automatic test_latency;
    bd[0] = 6'd7; bw1[0] = 6'h3d; bw2[0] = 6'd0;
    send_cfg(2'b11, 1);
    bus.in_valid = 1'b1;
    bus.in_d = bd[0]; bus.in_w1 = bw1[0]; bus.in_w2 = bw2[0];
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_d     = 6'd0;
      if (bus.out_valid !== (k == 3)) begin
        miscompares++;
        $display("FAIL latency: after edge E+%0d out_valid %b want %b", k - 1, bus.out_valid, k == 3);
      end
      if (bus.mul_d !== 6'd7) begin
        miscompares++;
        $display("FAIL mul_hold: after edge E+%0d mul_d %0d want 7", k - 1, bus.mul_d);
      end
      vectors += 2;
    end
    collect(2'b11, 5);
  endtask

  task automatic test_illegal_and_zero;
    send_cfg(2'b00, 5);
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_next: out_valid %b want 1", bus.out_valid);
    end
    vectors++;
    collect(2'b00, 0);
    send_cfg(2'b11, 0);
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_len_next: out_valid %b want 1", bus.out_valid);
    end
    vectors++;
    collect(2'b11, 0);
  endtask

  task automatic test_modes;
    for (int m = 1; m <= 2; m++) begin
      for (int i = 0; i < 6; i++) begin
        bd[i] = 6'($urandom); bw1[i] = 6'($urandom); bw2[i] = 6'($urandom);
      end
      run_job(2'(m), 6, 30, 1'b0);
    end
  endtask

  task automatic test_saturation;
    int   n = 0;
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      bd[i] = 6'd63; bw1[i] = 6'h20; bw2[i] = 6'd0;
    end
    @(negedge clk);
    bus16.cfg_valid = 1'b1; bus16.cfg_convtype = 2'b11; bus16.cfg_len = 8'd20;
    sb16.push_back(model(2'b11, 20, 16));
    @(negedge clk);
    bus16.cfg_valid = 1'b0;
    bus16.in_d = 6'd63; bus16.in_w1 = 6'h20; bus16.in_w2 = 6'd0;
    bus16.in_valid = 1'b1;
    repeat (20) @(negedge clk);
    bus16.in_valid = 1'b0;
    while (bus16.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    e = sb16.pop_front();
    if (bus16.out_valid !== 1'b1 || bus16.out_acc !== 16'(e.acc) || bus16.out_ovf !== e.ovf || bus16.out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL saturate16: valid %b acc %0d ovf %b err %b want 1 %0d %b 0",
               bus16.out_valid, $signed(bus16.out_acc), bus16.out_ovf, bus16.out_err, e.acc, e.ovf);
    end
    vectors++;
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
  endtask

  task automatic test_reset_midjob;
    bd[0] = 6'd9; bw1[0] = 6'd9; bd[1] = 6'd8; bw1[1] = 6'd8;
    send_cfg(2'b11, 5);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_d = bd[i]; bus.in_w1 = bw1[i]; bus.in_w2 = 6'd0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: busy %b in_ready %b want 1 1", bus.busy, bus.in_ready);
    end
    rst = 1'b1;
    #1;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: busy %b in_ready %b out_valid %b cfg_ready %b want 0 0 0 1",
               bus.busy, bus.in_ready, bus.out_valid, bus.cfg_ready);
    end
    vectors += 2;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    bd[0] = 6'd2; bw1[0] = 6'd3; bw2[0] = 6'd1;
    bd[1] = 6'd4; bw1[1] = 6'd5; bw2[1] = 6'd1;
    run_job(2'b11, 2, 0, 1'b0);
  endtask

  task automatic test_gaps;
    for (int i = 0; i < 255; i++) begin
      bd[i] = 6'($urandom); bw1[i] = 6'($urandom); bw2[i] = 6'($urandom);
    end
    run_job(2'b11, 255, 0, 1'b0);
    run_job(2'b11, 255, 40, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 4; i++) begin
        bd[i] = 6'($urandom); bw1[i] = 6'($urandom); bw2[i] = 6'($urandom);
      end
      run_job(2'b11, 4, 0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_convtype = 2'b00; bus.cfg_len = '0;
    bus.in_valid = 1'b0; bus.in_d = '0; bus.in_w1 = '0; bus.in_w2 = '0; bus.out_ready = 1'b0;
    bus16.cfg_valid = 1'b0; bus16.cfg_convtype = 2'b00; bus16.cfg_len = '0;
    bus16.in_valid = 1'b0; bus16.in_d = '0; bus16.in_w1 = '0; bus16.in_w2 = '0; bus16.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_basic;
    test_latency;
    test_illegal_and_zero;
    test_modes;
    test_saturation;
    test_reset_midjob;
    test_gaps;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
